mem_access_ctrl: RTL and testbench

//  Sequences main-memory transactions requested by the microcode RD/WR bits of the MIR.

---
 rtl/mac_pkg.sv | 34 +++
 rtl/mac_wait_counter.sv | 53 +++++
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the main-memory access controller:
//   - FSM state encoding (3-bit)
//   - transaction op-type encoding
//   - default timing parameters
//   - word-alignment helper
// -----------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } mac_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mac_op_t;

    localparam int unsigned MAC_DATAWIDTH_DEF   = 32;
    localparam int unsigned MAC_WAIT_STATES_DEF = 2;
    localparam int unsigned MAC_TIMEOUT_DEF     = 15;
    localparam int unsigned MAC_CNT_WIDTH_DEF   = 4;

    // Byte address is usable only when it points at a 32-bit word boundary.
    function automatic logic mac_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mac_wait_counter.sv
// -----------------------------------------------------------------------------
// mac_wait_counter
// Counts ACCESS cycles for the memory access controller. Saturates at TIMEOUT
// so a memory that never answers cannot wrap the count back below the limit.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   clear       in   forces count to zero (has priority over enable)
//   enable      in   advance the count by one (saturating)
//   count       out  current count
//   ge_wait     out  count >= WAIT_STATES (READY may be honoured)
//   at_timeout  out  count == TIMEOUT
// -----------------------------------------------------------------------------
module mac_wait_counter
    import mac_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = MAC_CNT_WIDTH_DEF,
    parameter int unsigned WAIT_STATES = MAC_WAIT_STATES_DEF,
    parameter int unsigned TIMEOUT     = MAC_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ge_wait,
    output logic                 at_timeout
);

    localparam logic [CNT_WIDTH-1:0] WAIT_C    = CNT_WIDTH'(WAIT_STATES);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_r;

    // Saturating wait/timeout counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (enable && (count_r != TIMEOUT_C)) begin
            count_r <= count_r + ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign count      = count_r;
    assign ge_wait    = (count_r >= WAIT_C);
    assign at_timeout = (count_r == TIMEOUT_C);

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences one main-memory transaction per RD/WR microword bit: latches the
// address/store data, drives the memory strobe through SETUP and ACCESS,
// waits at least WAIT_STATES access cycles before honouring READY, and
// returns a one-cycle ACK so the microsequencer can advance. A memory that
// never answers, a misaligned address or RD and WR together end in ERR,
// which still ACKs (no deadlock) and sets the sticky ERROR flag.
// Ports:
//   MAC_CLOCK_50          in   clock, all logic rising-edge
//   MAC_RESET_InLow       in   synchronous active-low reset
//   MAC_RD_InHigh         in   read request (MIR RD bit)
//   MAC_WR_InHigh         in   write request (MIR WR bit)
//   MAC_ADDR_InBUS        in   byte address (A bus)
//   MAC_DATA_InBUS        in   store data (B bus)
//   MAC_MEM_DATA_InBUS    in   load data from memory
//   MAC_MEM_READY_InHigh  in   memory ready/complete
//   MAC_MEM_ADDR_OutBUS   out  registered memory address
//   MAC_MEM_DATA_OutBUS   out  registered store data
//   MAC_MEM_RD_OutHigh    out  memory read strobe
//   MAC_MEM_WR_OutHigh    out  memory write strobe
//   MAC_DATA_OutBUS       out  last load data (C bus)
//   MAC_ACK_OutHigh       out  one-cycle completion pulse
//   MAC_ERROR_OutHigh     out  sticky fault flag
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = MAC_DATAWIDTH_DEF,
    parameter int unsigned WAIT_STATES   = MAC_WAIT_STATES_DEF,
    parameter int unsigned TIMEOUT       = MAC_TIMEOUT_DEF,
    parameter int unsigned CNT_WIDTH     = MAC_CNT_WIDTH_DEF
) (
    input  logic                     MAC_CLOCK_50,
    input  logic                     MAC_RESET_InLow,
    input  logic                     MAC_RD_InHigh,
    input  logic                     MAC_WR_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] MAC_ADDR_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MAC_DATA_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MAC_MEM_DATA_InBUS,
    input  logic                     MAC_MEM_READY_InHigh,
    output logic [DATAWIDTH_BUS-1:0] MAC_MEM_ADDR_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MAC_MEM_DATA_OutBUS,
    output logic                     MAC_MEM_RD_OutHigh,
    output logic                     MAC_MEM_WR_OutHigh,
    output logic [DATAWIDTH_BUS-1:0] MAC_DATA_OutBUS,
    output logic                     MAC_ACK_OutHigh,
    output logic                     MAC_ERROR_OutHigh
);

    mac_state_t               state_r;
    mac_op_t                  op_r;
    logic [DATAWIDTH_BUS-1:0] mem_addr_r;
    logic [DATAWIDTH_BUS-1:0] mem_data_r;
    logic [DATAWIDTH_BUS-1:0] data_out_r;
    logic                     mem_rd_r;
    logic                     mem_wr_r;
    logic                     ack_r;
    logic                     error_r;

    logic                     req_s;
    logic                     bad_req_s;
    logic [CNT_WIDTH-1:0]     cnt_s;
    logic                     ge_wait_s;
    logic                     at_timeout_s;

    assign req_s     = MAC_RD_InHigh | MAC_WR_InHigh;
    assign bad_req_s = (MAC_RD_InHigh & MAC_WR_InHigh) |
                       ~mac_word_aligned(MAC_ADDR_InBUS[1:0]);

    // The counter only runs in ACCESS; every other state holds it at zero,
    // which covers the SETUP clear.
    mac_wait_counter #(
        .CNT_WIDTH   (CNT_WIDTH),
        .WAIT_STATES (WAIT_STATES),
        .TIMEOUT     (TIMEOUT)
    ) u_wait_counter (
        .clk        (MAC_CLOCK_50),
        .rst_n      (MAC_RESET_InLow),
        .clear      (state_r != ACCESS),
        .enable     (state_r == ACCESS),
        .count      (cnt_s),
        .ge_wait    (ge_wait_s),
        .at_timeout (at_timeout_s)
    );

    // Transaction FSM with registered strobes, ACK, error flag and load data.
    // Outputs change on the same edge as the state, so the strobe is already
    // high in SETUP and ACK is high exactly during DONE/ERR.
    always_ff @(posedge MAC_CLOCK_50) begin
        if (!MAC_RESET_InLow) begin
            state_r    <= IDLE;
            op_r       <= OP_RD;
            mem_addr_r <= {DATAWIDTH_BUS{1'b0}};
            mem_data_r <= {DATAWIDTH_BUS{1'b0}};
            data_out_r <= {DATAWIDTH_BUS{1'b0}};
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 1'b0;
            ack_r      <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s && bad_req_s) begin
                        // Any request with RD high counts as a read-type fault.
                        state_r <= ERR;
                        ack_r   <= 1'b1;
                        error_r <= 1'b1;
                        if (MAC_RD_InHigh) begin
                            data_out_r <= {DATAWIDTH_BUS{1'b0}};
                        end else begin
                            data_out_r <= data_out_r;
                        end
                    end else if (req_s) begin
                        state_r    <= SETUP;
                        mem_addr_r <= MAC_ADDR_InBUS;
                        mem_data_r <= MAC_DATA_InBUS;
                        op_r       <= MAC_RD_InHigh ? OP_RD : OP_WR;
                        mem_rd_r   <= MAC_RD_InHigh;
                        mem_wr_r   <= MAC_WR_InHigh;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    // READY wins over timeout when both land on the last cycle.
                    if (ge_wait_s && MAC_MEM_READY_InHigh) begin
                        state_r  <= DONE;
                        mem_rd_r <= 1'b0;
                        mem_wr_r <= 1'b0;
                        ack_r    <= 1'b1;
                        if (op_r == OP_RD) begin
                            data_out_r <= MAC_MEM_DATA_InBUS;
                        end else begin
                            data_out_r <= data_out_r;
                        end
                    end else if (at_timeout_s) begin
                        state_r  <= ERR;
                        mem_rd_r <= 1'b0;
                        mem_wr_r <= 1'b0;
                        ack_r    <= 1'b1;
                        error_r  <= 1'b1;
                        if (op_r == OP_RD) begin
                            data_out_r <= {DATAWIDTH_BUS{1'b0}};
                        end else begin
                            data_out_r <= data_out_r;
                        end
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                ERR: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                end
            endcase
        end
    end

    assign MAC_MEM_ADDR_OutBUS = mem_addr_r;
    assign MAC_MEM_DATA_OutBUS = mem_data_r;
    assign MAC_MEM_RD_OutHigh  = mem_rd_r;
    assign MAC_MEM_WR_OutHigh  = mem_wr_r;
    assign MAC_DATA_OutBUS     = data_out_r;
    assign MAC_ACK_OutHigh     = ack_r;
    assign MAC_ERROR_OutHigh   = error_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Scoreboard bench: each issued request pushes its expected outcome (ACK
// cycle, strobe cycle counts, error flag, load data, latched address/data);
// an independent monitor pops and compares on every ACK.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int WS = 2;
    localparam int TO = 15;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic        ready  = 1'b0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] data   = 32'h0;
    logic [31:0] mrdata = 32'h0;

    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] dout;
    logic        ack;
    logic        error;

    mem_access_ctrl dut (
        .MAC_CLOCK_50         (clk),
        .MAC_RESET_InLow      (rst_n),
        .MAC_RD_InHigh        (rd),
        .MAC_WR_InHigh        (wr),
        .MAC_ADDR_InBUS       (addr),
        .MAC_DATA_InBUS       (data),
        .MAC_MEM_DATA_InBUS   (mrdata),
        .MAC_MEM_READY_InHigh (ready),
        .MAC_MEM_ADDR_OutBUS  (mem_addr),
        .MAC_MEM_DATA_OutBUS  (mem_data),
        .MAC_MEM_RD_OutHigh   (mem_rd),
        .MAC_MEM_WR_OutHigh   (mem_wr),
        .MAC_DATA_OutBUS      (dout),
        .MAC_ACK_OutHigh      (ack),
        .MAC_ERROR_OutHigh    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          ack_cyc;
        int          rd_cnt;
        int          wr_cnt;
        logic        err;
        logic [31:0] dout;
        logic [31:0] maddr;
        logic [31:0] mdata;
    } exp_t;

    exp_t exp_q[$];

    // Reference state derived from the transaction rules.
    logic        m_err   = 1'b0;
    logic [31:0] m_dout  = 32'h0;
    logic [31:0] m_maddr = 32'h0;
    logic [31:0] m_mdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: strobe cycles are counted between ACKs and compared on ACK.
    int   rd_seen = 0;
    int   wr_seen = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_seen = 0;
            wr_seen = 0;
        end else begin
            if (ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ACK with no pending request at cycle %0d", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_cycle", cyc, mon_e.ack_cyc);
                    chk("rd_strobe_cycles", rd_seen, mon_e.rd_cnt);
                    chk("wr_strobe_cycles", wr_seen, mon_e.wr_cnt);
                    chk("error_flag", {31'b0, error}, {31'b0, mon_e.err});
                    chk("load_data", dout, mon_e.dout);
                    chk("mem_addr", mem_addr, mon_e.maddr);
                    chk("mem_store_data", mem_data, mon_e.mdata);
                end
                rd_seen = 0;
                wr_seen = 0;
            end
            if (mem_rd) rd_seen++;
            if (mem_wr) wr_seen++;
        end
    end

    // Issue one request at a negedge with the DUT in IDLE. READY is first
    // sampled high at the rs-th rising edge after the request edge.
    task automatic do_txn(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] md, input int rs);
        exp_t e;
        int   tack;
        int   a_done;
        bit   legal;
        bit   got;
        legal = (r ^ w) && (a[1:0] == 2'b00);
        if (!legal) begin
            tack  = 0;
            m_err = 1'b1;
            if (r) m_dout = 32'h0;
        end else begin
            m_maddr = a;
            m_mdata = d;
            // Access cycles are numbered 0,1,2,... starting two edges after the request.
            a_done = (rs - 2 > WS) ? rs - 2 : WS;
            if (a_done <= TO) begin
                tack = a_done + 2;
                if (r) m_dout = md;
            end else begin
                tack  = TO + 2;
                m_err = 1'b1;
                if (r) m_dout = 32'h0;
            end
        end
        e.ack_cyc = cyc + 1 + tack;
        e.rd_cnt  = (legal && r) ? tack : 0;
        e.wr_cnt  = (legal && w) ? tack : 0;
        e.err     = m_err;
        e.dout    = m_dout;
        e.maddr   = m_maddr;
        e.mdata   = m_mdata;
        exp_q.push_back(e);

        rd     = r;
        wr     = w;
        addr   = a;
        data   = d;
        mrdata = md;
        ready  = (rs <= 0);
        got    = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            // Inputs other than memory data are don't-care once the request is taken.
            rd   = 1'b0;
            wr   = 1'b0;
            addr = $urandom;
            data = $urandom;
            if (ack) got = 1'b1;
            ready = (k + 1 >= rs);
        end
        ready = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: got no ACK within 60 cycles expected one at cycle %0d", e.ack_cyc);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Reset while ACCESS has counted one cycle: strobes drop, no ACK follows.
    task automatic reset_mid_access();
        rd    = 1'b1;
        addr  = 32'h0000_0080;
        ready = 1'b0;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("strobe_before_reset", {31'b0, mem_rd}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mem_rd", {31'b0, mem_rd}, 32'h0);
        chk("reset_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_error", {31'b0, error}, 32'h0);
        chk("reset_load_data", dout, 32'h0);
        m_err   = 1'b0;
        m_dout  = 32'h0;
        m_maddr = 32'h0;
        m_mdata = 32'h0;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        int sel;
        logic [31:0] ra;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_error", {31'b0, error}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);   // read, READY always
        do_txn(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_0001, 8); // slow write
        do_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h5555_AAAA, 999); // timeout
        do_txn(1'b1, 1'b1, 32'h0000_0300, 32'h0, 32'h0, 0);           // RD and WR
        do_txn(1'b1, 1'b0, 32'h0000_0042, 32'h0, 32'h0, 0);           // misaligned
        do_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 1);   // early READY
        reset_mid_access();
        do_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 3);   // read after reset
        do_txn(1'b0, 1'b1, 32'h0000_0084, 32'hFEED_FACE, 32'h2468_ACE0, 17); // last-cycle READY

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom & 32'hFFFF_FFFC;
            if (sel < 4) begin
                do_txn(1'b1, 1'b0, ra, $urandom, $urandom, $urandom_range(0, 12));
            end else if (sel < 8) begin
                do_txn(1'b0, 1'b1, ra, $urandom, $urandom, $urandom_range(0, 12));
            end else if (sel == 8) begin
                do_txn(1'b1, 1'b0, ra | 32'(($urandom_range(1, 3))), $urandom, $urandom, 0);
            end else begin
                do_txn(1'b0, 1'b1, ra, $urandom, $urandom, $urandom_range(16, 20));
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        chk("final_error", {31'b0, error}, {31'b0, m_err});
        chk("final_load_data", dout, m_dout);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
